if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch.sv | 161 ++++++++++++++++
 tb/tb_if_prefetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction fetch prefetcher: credit-limited request issue, in-order
// response pairing through an address queue, and a circular instruction
// buffer toward decode. Redirects flush the buffer and drop every response
// still in flight for the old stream.
// Optional macro IF_PREFETCH_BYPASS_EN: a kept response arriving while the
// buffer is empty is presented to decode in the same cycle.
module if_prefetch #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [INST_W-1:0] mem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc
);

   localparam int unsigned       IW  = $clog2(DEPTH);
   localparam int unsigned       PW  = IW + 1;
   localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PW-1:0]     out_q, out_d;
   logic [PW-1:0]     drop_q, drop_d;
   logic [PW-1:0]     wr_q, wr_d;
   logic [PW-1:0]     rd_q, rd_d;
   logic [IW-1:0]     aqw_q, aqw_d;
   logic [IW-1:0]     aqr_q, aqr_d;
   logic [ADDR_W-1:0] aq_q  [DEPTH];
   logic [ADDR_W-1:0] aq_d  [DEPTH];
   logic [ADDR_W-1:0] bpc_q [DEPTH];
   logic [ADDR_W-1:0] bpc_d [DEPTH];
   logic [INST_W-1:0] bin_q [DEPTH];
   logic [INST_W-1:0] bin_d [DEPTH];

   logic [PW-1:0]     occ;
   logic [PW:0]       load;
   logic              empty;
   logic              credit_ok;
   logic              acc;
   logic              kept;
   logic              bypass_hit;
   logic              push;
   logic              pop_buf;
   logic [ADDR_W-1:0] rsp_pc;
   logic [IW-1:0]     rd_idx;

   assign occ       = wr_q - rd_q;
   assign empty     = (wr_q == rd_q);
   assign load      = {1'b0, out_q} + {1'b0, occ};
   assign credit_ok = load < (PW+1)'(DEPTH);
   assign rd_idx    = rd_q[IW-1:0];
   assign rsp_pc    = aq_q[aqr_q];

   assign mem_req_valid = !rst && !redirect_valid && credit_ok;
   assign mem_req_addr  = pc_q;
   assign acc           = mem_req_valid && mem_req_ready;
   assign kept          = mem_rsp_valid && !redirect_valid && (drop_q == '0);

`ifdef IF_PREFETCH_BYPASS_EN
   assign bypass_hit = kept && empty;
`else
   assign bypass_hit = 1'b0;
`endif

   assign inst_valid = !rst && (!empty || bypass_hit);
   assign pop_buf    = inst_valid && inst_ready && !empty;
   // A bypassed response consumed by decode in its arrival cycle is never stored.
   assign push       = kept && !(bypass_hit && inst_ready);

   // Decode-side view: buffer head, or the arriving response when bypassing.
   always_comb begin
      inst    = NOP;
      inst_pc = '0;
      if (inst_valid) begin
         if (empty) begin
            inst    = mem_rsp_data;
            inst_pc = rsp_pc;
         end else begin
            inst    = bin_q[rd_idx];
            inst_pc = bpc_q[rd_idx];
         end
      end
   end

   // Next-state for fetch PC, credit/drop counters, address queue and buffer.
   always_comb begin
      pc_d   = pc_q;
      out_d  = out_q + PW'(acc) - PW'(mem_rsp_valid);
      drop_d = drop_q;
      aqw_d  = aqw_q + IW'(acc);
      aqr_d  = aqr_q + IW'(mem_rsp_valid);
      aq_d   = aq_q;
      wr_d   = wr_q + PW'(push);
      rd_d   = rd_q + PW'(pop_buf);
      bpc_d  = bpc_q;
      bin_d  = bin_q;

      if (acc) begin
         aq_d[aqw_q] = pc_q;
      end
      if (push) begin
         bpc_d[wr_q[IW-1:0]] = rsp_pc;
         bin_d[wr_q[IW-1:0]] = mem_rsp_data;
      end

      // The address queue keeps popping on dropped responses so pairing
      // stays aligned; only the buffer is flushed on a redirect.
      if (redirect_valid) begin
         pc_d   = redirect_pc;
         rd_d   = wr_q;
         drop_d = out_q - PW'(mem_rsp_valid);
      end else begin
         if (acc) begin
            pc_d = pc_q + ADDR_W'(4);
         end
         if (mem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - PW'(1);
         end
      end
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         aqw_q  <= '0;
         aqr_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         aqw_q  <= aqw_d;
         aqr_q  <= aqr_d;
      end
   end

   // Storage arrays; contents are qualified by the pointers, so no reset.
   always_ff @(posedge clk) begin
      aq_q  <= aq_d;
      bpc_q <= bpc_d;
      bin_q <= bin_d;
   end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: table of per-cycle vectors for the
// streaming/stall timing, hand sequences for backpressure, redirects and
// mid-run reset, with an in-order scoreboard on every delivered instruction.
module tb_if_prefetch;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   localparam logic [31:0] NOP = 32'h0000_0013;

   if_prefetch #(
      .ADDR_W   (32),
      .INST_W   (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   typedef struct {
      logic        ir;
      logic        rv;
      logic [31:0] ra;
      logic        iv;
      logic [31:0] ipc;
   } vec_t;

   mreq_t       mq[$];
   vec_t        tbl[13];
   int unsigned cyc;
   int unsigned lat;
   int          total;
   int          bad;
   int          nacc;
   int          ndel;
   logic [31:0] exp_pc;
   logic        first_seen;
   logic [31:0] first_pc;

   logic        s_req_v;
   logic [31:0] s_req_addr;
   logic        s_iv;
   logic [31:0] s_ipc;
   logic [31:0] s_inst;

   function automatic logic [31:0] fdat(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: memory drives, outputs sampled, scoreboard/memory updated.
   task automatic tick();
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = fdat(mq[0].addr);
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
      #1;
      s_req_v    = mem_req_valid;
      s_req_addr = mem_req_addr;
      s_iv       = inst_valid;
      s_ipc      = inst_pc;
      s_inst     = inst;
      if (!rst && s_iv && inst_ready) begin
         chk("order_pc", s_ipc, exp_pc);
         chk("order_inst", s_inst, fdat(exp_pc));
         if (!first_seen) begin
            first_seen = 1'b1;
            first_pc   = s_ipc;
         end
         exp_pc = exp_pc + 32'd4;
         ndel++;
      end
      if (!rst && s_req_v && mem_req_ready) begin
         mq.push_back('{addr: s_req_addr, due: cyc + lat});
         nacc++;
      end
      if (mem_rsp_valid) void'(mq.pop_front());
      if (redirect_valid) exp_pc = redirect_pc;
      if (rst) begin
         mq.delete();
         exp_pc = 32'h0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      tick();
      chk("rst_reqv", {31'b0, s_req_v}, 32'd0);
      chk("rst_iv", {31'b0, s_iv}, 32'd0);
      chk("rst_inst", s_inst, NOP);
      chk("rst_ipc", s_ipc, 32'h0);
      rst        = 1'b0;
      first_seen = 1'b0;
   endtask

   int a0;
   int d0;

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      mem_req_ready = 1'b1; inst_ready = 1'b0;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      cyc = 0; lat = 1; total = 0; bad = 0; nacc = 0; ndel = 0;
      exp_pc = '0; first_seen = 1'b0; first_pc = '0;

      //            ir    rv    ra         iv    ipc
      tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
      tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
      tbl[7]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
      tbl[8]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
      tbl[9]  = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
      tbl[10] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
      tbl[11] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
      tbl[12] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};

      do_reset();
      do_reset();

      // Streaming, stall, single-pop resume timing from reset.
`ifndef IF_PREFETCH_BYPASS_EN
      for (int i = 0; i < 13; i++) begin
         inst_ready = tbl[i].ir;
         tick();
         chk($sformatf("vec%0d_reqv", i), {31'b0, s_req_v}, {31'b0, tbl[i].rv});
         if (tbl[i].rv) chk($sformatf("vec%0d_addr", i), s_req_addr, tbl[i].ra);
         chk($sformatf("vec%0d_iv", i), {31'b0, s_iv}, {31'b0, tbl[i].iv});
         if (tbl[i].iv) chk($sformatf("vec%0d_ipc", i), s_ipc, tbl[i].ipc);
         else           chk($sformatf("vec%0d_nop", i), s_inst, NOP);
      end
`else
      inst_ready = 1'b1;
      tick();
      chk("byp_c0_iv", {31'b0, s_iv}, 32'd0);
      tick();
      chk("byp_c1_iv", {31'b0, s_iv}, 32'd1);
      chk("byp_c1_ipc", s_ipc, 32'h0);
`endif

      // Backpressure: exactly DEPTH requests, then one more per pop.
      lat = 1;
      do_reset();
      inst_ready = 1'b0;
      a0 = nacc;
      repeat (12) tick();
      chk("stall_acc", a0 + 4, nacc);
      chk("stall_reqv", {31'b0, s_req_v}, 32'd0);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      a0 = nacc;
      repeat (8) tick();
      chk("resume_acc", a0 + 1, nacc);
      // Continuous consume from a full buffer with wrapping pointers.
      inst_ready = 1'b1;
      d0 = ndel;
      repeat (20) tick();
      chk("stream_cnt", d0 + 20, ndel);

      // Redirect with three requests in flight.
      lat = 4;
      do_reset();
      inst_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      chk("redir_reqv", {31'b0, s_req_v}, 32'd0);
      redirect_valid = 1'b0;
      first_seen     = 1'b0;
      tick();
      chk("post_redir_iv", {31'b0, s_iv}, 32'd0);
      repeat (20) tick();
      chk("redir_seen", {31'b0, first_seen}, 32'd1);
      chk("redir_first_pc", first_pc, 32'h100);

      // Redirect coinciding with a response, then a second redirect.
      lat = 2;
      do_reset();
      inst_ready = 1'b1;
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      chk("redir2a_rsp", {31'b0, mem_rsp_valid}, 32'd1);
      redirect_valid = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_valid = 1'b0;
      first_seen     = 1'b0;
      d0 = ndel;
      repeat (20) tick();
      chk("redir2_seen", {31'b0, first_seen}, 32'd1);
      chk("redir2_first_pc", first_pc, 32'h300);
      chk("redir2_count", {31'b0, (ndel - d0) >= 10}, 32'd1);

      // Reset in the middle of traffic.
      lat = 2;
      do_reset();
      inst_ready = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_reqv", {31'b0, s_req_v}, 32'd0);
      chk("mid_rst_iv", {31'b0, s_iv}, 32'd0);
      chk("mid_rst_inst", s_inst, NOP);
      rst = 1'b0;
      tick();
      chk("after_rst_iv", {31'b0, s_iv}, 32'd0);
      chk("after_rst_inst", s_inst, NOP);
      chk("after_rst_reqv", {31'b0, s_req_v}, 32'd1);
      chk("after_rst_addr", s_req_addr, 32'h0);
      inst_ready = 1'b1;
      first_seen = 1'b0;
      repeat (10) tick();
      chk("after_rst_seen", {31'b0, first_seen}, 32'd1);
      chk("after_rst_first_pc", first_pc, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
